// File: rtl/axi_b_buffer_v2.sv
// AXI write-response (B) channel FIFO with optional fall-through, fill status and flush.
// Define AXI_B_BUFFER_V2_ERR_CNT_EN to build the SLVERR/DECERR delivery counters.
module axi_b_buffer_v2 #(
  parameter int ID_WIDTH     = 4,
  parameter int USER_WIDTH   = 1,
  parameter int BUFFER_DEPTH = 4,
  parameter int FALL_THROUGH = 0,
  parameter int AFULL_THRESH = BUFFER_DEPTH - 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            test_en_i,
  input  logic                            flush_i,
  input  logic                            slave_valid_i,
  input  logic [1:0]                      slave_resp_i,
  input  logic [ID_WIDTH-1:0]             slave_id_i,
  input  logic [USER_WIDTH-1:0]           slave_user_i,
  output logic                            slave_ready_o,
  output logic                            master_valid_o,
  output logic [1:0]                      master_resp_o,
  output logic [ID_WIDTH-1:0]             master_id_o,
  output logic [USER_WIDTH-1:0]           master_user_o,
  input  logic                            master_ready_i,
  output logic [$clog2(BUFFER_DEPTH):0]   level_o,
  output logic                            almost_full_o,
  output logic                            empty_o,
  input  logic                            err_clr_i,
  output logic [15:0]                     slverr_cnt_o,
  output logic [15:0]                     decerr_cnt_o
);

  localparam int PTR_W  = $clog2(BUFFER_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BEAT_W = ID_WIDTH + USER_WIDTH + 2;

  logic [BEAT_W-1:0] mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty_q, empty_d, afull_q, afull_d;
  logic              full, bypass, push, pop, wr_en, rd_en;
  logic [BEAT_W-1:0] slave_beat, out_beat;
  logic              unused_test_en;

  assign unused_test_en = test_en_i;

  assign slave_beat = {slave_id_i, slave_user_i, slave_resp_i};
  assign full       = (level_q == LVL_W'(BUFFER_DEPTH));
  assign bypass     = (FALL_THROUGH != 0) && empty_q && slave_valid_i;

  assign slave_ready_o  = !full && !flush_i;
  assign master_valid_o = (!empty_q || bypass) && !flush_i;

  assign push = slave_valid_i && slave_ready_o;
  assign pop  = master_valid_o && master_ready_i;
  // A bypassed beat that is taken the same cycle never touches the array.
  assign wr_en = push && !(bypass && master_ready_i);
  assign rd_en = pop && !bypass;

  assign out_beat = bypass ? slave_beat : mem_q[rptr_q];
  assign {master_id_o, master_user_o, master_resp_o} = out_beat;

  assign level_o       = level_q;
  assign empty_o       = empty_q;
  assign almost_full_o = afull_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PTR_W'(1);
      if (rd_en) rptr_d = rptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
    empty_d = (level_d == '0);
    afull_d = (level_d >= LVL_W'(AFULL_THRESH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
    end
  end

  // Storage is data only; its contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= slave_beat;
  end

`ifdef AXI_B_BUFFER_V2_ERR_CNT_EN
  logic [15:0] slverr_q, slverr_d, decerr_q, decerr_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    slverr_d = slverr_q;
    decerr_d = decerr_q;
    if (err_clr_i) begin
      slverr_d = '0;
      decerr_d = '0;
    end else if (pop) begin
      if (master_resp_o == 2'b10) slverr_d = sat_inc(slverr_q);
      if (master_resp_o == 2'b11) decerr_d = sat_inc(decerr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slverr_q <= '0;
      decerr_q <= '0;
    end else begin
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
    end
  end

  assign slverr_cnt_o = slverr_q;
  assign decerr_cnt_o = decerr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign slverr_cnt_o   = '0;
  assign decerr_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_axi_b_buffer_v2.sv
// Bench for axi_b_buffer_v2: instance 0 is FALL_THROUGH=0, instance 1 is FALL_THROUGH=1.
module tb_axi_b_buffer_v2;

`ifdef AXI_B_BUFFER_V2_ERR_CNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef logic [6:0] beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tst = 1'b0;
  logic        flush [2];
  logic        sv    [2];
  logic [1:0]  sresp [2];
  logic [3:0]  sid   [2];
  logic        suser [2];
  logic        sr    [2];
  logic        mv    [2];
  logic [1:0]  mresp [2];
  logic [3:0]  mid   [2];
  logic        muser [2];
  logic        mr    [2];
  logic [2:0]  lvl   [2];
  logic        af    [2];
  logic        em    [2];
  logic        eclr  [2];
  logic [15:0] slv   [2];
  logic [15:0] dec   [2];

  int checks   = 0;
  int failures = 0;

  beat_t q0[$];
  beat_t q1[$];
  int    slv_m [2];
  int    dec_m [2];

  logic [1:0] rs_tab [6];

  always #5 clk = ~clk;

  axi_b_buffer_v2 #(.ID_WIDTH(4), .USER_WIDTH(1), .BUFFER_DEPTH(4), .FALL_THROUGH(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .test_en_i(tst), .flush_i(flush[0]),
    .slave_valid_i(sv[0]), .slave_resp_i(sresp[0]), .slave_id_i(sid[0]), .slave_user_i(suser[0]),
    .slave_ready_o(sr[0]), .master_valid_o(mv[0]), .master_resp_o(mresp[0]), .master_id_o(mid[0]),
    .master_user_o(muser[0]), .master_ready_i(mr[0]), .level_o(lvl[0]), .almost_full_o(af[0]),
    .empty_o(em[0]), .err_clr_i(eclr[0]), .slverr_cnt_o(slv[0]), .decerr_cnt_o(dec[0])
  );

  axi_b_buffer_v2 #(.ID_WIDTH(4), .USER_WIDTH(1), .BUFFER_DEPTH(4), .FALL_THROUGH(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .test_en_i(tst), .flush_i(flush[1]),
    .slave_valid_i(sv[1]), .slave_resp_i(sresp[1]), .slave_id_i(sid[1]), .slave_user_i(suser[1]),
    .slave_ready_o(sr[1]), .master_valid_o(mv[1]), .master_resp_o(mresp[1]), .master_id_o(mid[1]),
    .master_user_o(muser[1]), .master_ready_i(mr[1]), .level_o(lvl[1]), .almost_full_o(af[1]),
    .empty_o(em[1]), .err_clr_i(eclr[1]), .slverr_cnt_o(slv[1]), .decerr_cnt_o(dec[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each instance is a bounded queue of beats judged at the falling edge,
  // then advanced by the handshakes that the next rising edge will perform.
  task automatic model_step(input int k);
    int    sz;
    beat_t hd, inb, outb;
    bit    full, byp, ev, push, pop;
    if (rst) begin
      if (k == 0) q0.delete(); else q1.delete();
      slv_m[k] = 0;
      dec_m[k] = 0;
    end
    sz = (k == 0) ? q0.size() : q1.size();
    hd = '0;
    if (sz > 0) hd = (k == 0) ? q0[0] : q1[0];
    inb  = {sid[k], suser[k], sresp[k]};
    full = (sz == 4);
    byp  = (k == 1) && (sz == 0) && sv[k];
    ev   = ((sz != 0) || byp) && !flush[k];
    outb = byp ? inb : hd;
    chk($sformatf("m%0d_srdy", k), sr[k], !full && !flush[k]);
    chk($sformatf("m%0d_mvalid", k), mv[k], ev);
    if (ev) chk($sformatf("m%0d_beat", k), {mid[k], muser[k], mresp[k]}, outb);
    chk($sformatf("m%0d_level", k), lvl[k], sz);
    chk($sformatf("m%0d_afull", k), af[k], sz >= 3);
    chk($sformatf("m%0d_empty", k), em[k], sz == 0);
    chk($sformatf("m%0d_slverr", k), slv[k], ERR_ON ? slv_m[k] : 0);
    chk($sformatf("m%0d_decerr", k), dec[k], ERR_ON ? dec_m[k] : 0);
    if (!rst) begin
      push = sv[k] && !full && !flush[k];
      pop  = ev && mr[k];
      if (eclr[k]) begin
        slv_m[k] = 0;
        dec_m[k] = 0;
      end else if (pop) begin
        if (outb[1:0] == 2'b10 && slv_m[k] < 65535) slv_m[k]++;
        if (outb[1:0] == 2'b11 && dec_m[k] < 65535) dec_m[k]++;
      end
      if (flush[k]) begin
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        if (pop && !byp) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (push && !(byp && pop)) begin
          if (k == 0) q0.push_back(inb); else q1.push_back(inb);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rs_tab = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
    for (int k = 0; k < 2; k++) begin
      flush[k] = 0; sv[k] = 0; sresp[k] = 0; sid[k] = 0; suser[k] = 0; mr[k] = 0; eclr[k] = 0;
    end
    step();
    step();
    rst = 0;
    #1;
    chk("reset_srdy", sr[0], 1);
    chk("reset_level", lvl[0], 0);

    // Fill to full with no downstream ready, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      sv[0] = 1; sid[0] = 4'(i); suser[0] = i[0]; sresp[0] = 2'b00;
      step();
      #1;
      chk("fill_level", lvl[0], i);
      chk("fill_afull", af[0], i >= 3);
    end
    chk("full_srdy", sr[0], 0);
    sv[0] = 0;
    mr[0] = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_id", mid[0], i);
      step();
    end
    #1;
    chk("drain_empty", em[0], 1);

    // Streaming: one beat per cycle, level holds at 1.
    for (int i = 0; i < 20; i++) begin
      sv[0] = 1; sid[0] = 4'(i); suser[0] = 0; sresp[0] = 2'b00;
      step();
      #1;
      chk("stream_level", lvl[0], 1);
    end
    sv[0] = 0;
    step();
    step();
    mr[0] = 0;

    // Fall-through: same-cycle bypass, then stalled beat gets stored.
    sv[1] = 1; sid[1] = 4'd7; sresp[1] = 2'b00; suser[1] = 1; mr[1] = 1;
    #1;
    chk("ft_id", mid[1], 7);
    chk("ft_valid", mv[1], 1);
    step();
    sv[1] = 0;
    #1;
    chk("ft_level", lvl[1], 0);
    sv[1] = 1; sid[1] = 4'd5; mr[1] = 0;
    step();
    sv[1] = 0;
    #1;
    chk("ft_stored_level", lvl[1], 1);
    chk("ft_stored_id", mid[1], 5);
    mr[1] = 1;
    step();
    mr[1] = 0;

    // Flush with a valid beat offered: nothing accepted, buffer emptied.
    for (int i = 9; i <= 11; i++) begin
      sv[0] = 1; sid[0] = 4'(i);
      step();
    end
    flush[0] = 1; sid[0] = 4'd12;
    #1;
    chk("flush_srdy", sr[0], 0);
    chk("flush_mvalid", mv[0], 0);
    step();
    flush[0] = 0; sv[0] = 0;
    #1;
    chk("flush_level", lvl[0], 0);
    chk("flush_mvalid_after", mv[0], 0);
    sv[0] = 1; sid[0] = 4'd13;
    step();
    sv[0] = 0;
    #1;
    chk("post_flush_id", mid[0], 13);
    mr[0] = 1;
    step();

    // Error counters: 3 SLVERR, 2 DECERR, 1 OKAY.
    for (int i = 0; i < 6; i++) begin
      sv[0] = 1; sid[0] = 4'(i); sresp[0] = rs_tab[i];
      step();
    end
    sv[0] = 0;
    step();
    step();
    chk("cnt_slverr", slv[0], ERR_ON ? 3 : 0);
    chk("cnt_decerr", dec[0], ERR_ON ? 2 : 0);
    sv[0] = 1; sresp[0] = 2'b10;
    step();
    sv[0] = 0; eclr[0] = 1;
    step();
    eclr[0] = 0;
    #1;
    chk("clr_slverr", slv[0], 0);
    chk("clr_decerr", dec[0], 0);
    mr[0] = 0;

    // Asynchronous reset with two beats stored.
    for (int i = 1; i <= 2; i++) begin
      sv[0] = 1; sid[0] = 4'(i); sresp[0] = 2'b00;
      step();
    end
    sv[0] = 0;
    #1;
    chk("prerst_level", lvl[0], 2);
    rst = 1;
    #1;
    chk("arst_mvalid", mv[0], 0);
    chk("arst_level", lvl[0], 0);
    chk("arst_empty", em[0], 1);
    chk("arst_srdy", sr[0], 1);
    step();
    rst = 0;
    step();
    #1;
    chk("postrst_mvalid", mv[0], 0);
    chk("postrst_level", lvl[0], 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
